// File: rtl/musicbox_mode_controller_if.sv
// SDRAM-side request/acknowledge port of the MusicBox mode controller.
// The controller is the master. The SDRAM interface sits behind the slave modport.
interface musicbox_mode_controller_if #(
  parameter int ADDR_W = 24
) ();
  // Handshake rules:
  // - mem_req is the valid. It rises with mem_write, mem_address and mem_writeData
  //   already settled, and it holds all of them until the one-cycle mem_ack (the ready).
  // - mem_ack also qualifies mem_readData.
  // - An ack that arrives while mem_req is low carries no meaning.
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_writeData;
  logic              mem_ack;
  logic [15:0]       mem_readData;

  modport master (
    output mem_req, mem_write, mem_address, mem_writeData,
    input  mem_ack, mem_readData
  );

  modport slave (
    input  mem_req, mem_write, mem_address, mem_writeData,
    output mem_ack, mem_readData
  );
endinterface

// File: rtl/musicbox_mode_controller.sv
// MusicBox operating-mode controller: conditions the GPIO keys/buttons and arbitrates
// song playback, recording and replay, streaming sample-rate key state through SDRAM.
module musicbox_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SAMPLE_DIV      = 6250,
  parameter int MAX_REC_SAMPLES = 240000,
  parameter int ADDR_W          = 24
) (
  input  logic                       max10Board_50MhzClock,
  input  logic                       reset_n,
  input  logic [5:0]                 max10Board_GPIO_Input_MusicKeys,
  input  logic                       max10Board_GPIO_Input_PlaySong0,
  input  logic                       max10Board_GPIO_Input_PlaySong1,
  input  logic                       max10Board_GPIO_Input_MakeRecording,
  input  logic                       max10Board_GPIO_Input_PlayRecording,
  input  logic                       song_done,
  musicbox_mode_controller_if.master mem_if,
  output logic [5:0]                 keys_live,
  output logic [5:0]                 keys_playback,
  output logic                       song_enable,
  output logic                       song_select,
  output logic [2:0]                 mode,
  output logic [ADDR_W-1:0]          rec_length,
  output logic                       overrun
);
  localparam int NIN = 10;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SONG0    = 3'd1,
    S_SONG1    = 3'd2,
    S_RECORD   = 3'd3,
    S_PLAYBACK = 3'd4,
    S_DRAIN    = 3'd5
  } state_t;

  logic             clk;
  logic [NIN-1:0]   w_raw;
  logic [NIN-1:0]   r_sync1, r_sync2, r_deb_n, r_press;
  logic [DW-1:0]    r_db_cnt [NIN];
  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  state_t           r_state, w_next_state;
  logic             r_mem_req, r_mem_write;
  logic [ADDR_W-1:0] r_mem_address, r_rec_ptr, r_play_ptr, r_rec_length;
  logic [15:0]      r_mem_wdata;
  logic [5:0]       r_keys_playback;
  logic             r_overrun;
  logic             w_press_s0, w_press_s1, w_press_mk, w_press_pr, w_any_press;
  logic             w_ack, w_busy_after, w_streaming, w_issue, w_drop;
  logic [ADDR_W-1:0] w_rec_ptr_inc, w_play_ptr_inc;
  logic             w_rec_full, w_play_done, w_play_ok;
  logic             w_unused;

  assign clk   = max10Board_50MhzClock;
  assign w_raw = {max10Board_GPIO_Input_PlayRecording, max10Board_GPIO_Input_MakeRecording,
                  max10Board_GPIO_Input_PlaySong1, max10Board_GPIO_Input_PlaySong0,
                  max10Board_GPIO_Input_MusicKeys};

  // Debounced levels stay in raw active-low form. A press is flagged when the level commits low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb_n <= '1;
      r_press <= '0;
      for (int i = 0; i < NIN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_deb_n[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb_n[i]  <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_press[i]  <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign keys_live   = ~r_deb_n[5:0];
  assign w_press_s0  = r_press[6];
  assign w_press_s1  = r_press[7];
  assign w_press_mk  = r_press[8];
  assign w_press_pr  = r_press[9];
  assign w_any_press = |r_press[9:6];
  assign w_unused    = ^{mem_if.mem_readData[15:6], r_press[5:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end
  assign w_tick = (r_tick_cnt == TW'(SAMPLE_DIV - 1));

  assign w_ack          = mem_if.mem_ack & r_mem_req;
  assign w_busy_after   = r_mem_req & ~w_ack;
  assign w_rec_ptr_inc  = r_rec_ptr + ADDR_W'(1);
  assign w_play_ptr_inc = r_play_ptr + ADDR_W'(1);
  assign w_rec_full     = (w_rec_ptr_inc == ADDR_W'(MAX_REC_SAMPLES));
  assign w_play_done    = (w_play_ptr_inc == r_rec_length);
  // A refused PlayRecording lets the next-priority button through.
  assign w_play_ok      = w_press_pr & (r_rec_length != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_press_mk)      w_next_state = S_RECORD;
        else if (w_play_ok)  w_next_state = S_PLAYBACK;
        else if (w_press_s0) w_next_state = S_SONG0;
        else if (w_press_s1) w_next_state = S_SONG1;
      end
      S_SONG0, S_SONG1: begin
        if (song_done || w_any_press) w_next_state = S_IDLE;
      end
      S_RECORD: begin
        if (w_any_press || (w_ack && w_rec_full))
          w_next_state = w_busy_after ? S_DRAIN : S_IDLE;
      end
      S_PLAYBACK: begin
        if (w_ack && w_play_done) w_next_state = S_IDLE;
        else if (w_any_press)     w_next_state = w_busy_after ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!w_busy_after) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_streaming = (r_state == S_RECORD) || (r_state == S_PLAYBACK);
  assign w_issue     = w_tick & ~r_mem_req & w_streaming & (w_next_state == r_state);
  assign w_drop      = w_tick & r_mem_req & w_streaming;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req       <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_wdata     <= '0;
      r_rec_ptr       <= '0;
      r_play_ptr      <= '0;
      r_rec_length    <= '0;
      r_keys_playback <= '0;
      r_overrun       <= 1'b0;
    end else begin
      if (w_ack) begin
        r_mem_req <= 1'b0;
      end else if (w_issue) begin
        r_mem_req     <= 1'b1;
        r_mem_write   <= (r_state == S_RECORD);
        r_mem_address <= (r_state == S_RECORD) ? r_rec_ptr : r_play_ptr;
        r_mem_wdata   <= {10'b0, keys_live};
      end
      if (w_drop) r_overrun <= 1'b1;
      // The ack's direction comes from the request it completes, so a draining write still counts.
      if (w_ack) begin
        if (r_mem_write) begin
          r_rec_ptr    <= w_rec_ptr_inc;
          r_rec_length <= w_rec_ptr_inc;
        end else begin
          r_keys_playback <= mem_if.mem_readData[5:0];
          r_play_ptr      <= w_play_ptr_inc;
        end
      end
      if (r_state == S_IDLE && w_next_state == S_RECORD) begin
        r_rec_ptr    <= '0;
        r_rec_length <= '0;
        r_overrun    <= 1'b0;
      end
      if (r_state == S_IDLE && w_next_state == S_PLAYBACK) r_play_ptr <= '0;
      if (r_state != S_IDLE && w_next_state == S_IDLE) r_keys_playback <= '0;
    end
  end

  assign mem_if.mem_req       = r_mem_req;
  assign mem_if.mem_write     = r_mem_write;
  assign mem_if.mem_address   = r_mem_address;
  assign mem_if.mem_writeData = r_mem_wdata;
  assign keys_playback        = r_keys_playback;
  assign song_enable          = (r_state == S_SONG0) || (r_state == S_SONG1);
  assign song_select          = (r_state == S_SONG1);
  assign mode                 = r_state;
  assign rec_length           = r_rec_length;
  assign overrun              = r_overrun;
endmodule

// File: tb/tb_musicbox_mode_controller.sv
// Bench for musicbox_mode_controller: a latency-programmable SDRAM responder plus a
// transaction-level model of what recording and replay must put on the memory port.
module tb_musicbox_mode_controller;
  localparam int DEB  = 4;
  localparam int DIV  = 8;
  localparam int MAXS = 5;
  localparam int AW   = 24;
  localparam logic [3:0] B_PS0 = 4'b0001;
  localparam logic [3:0] B_PS1 = 4'b0010;
  localparam logic [3:0] B_MK  = 4'b0100;
  localparam logic [3:0] B_PR  = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    keys_n;
  logic [3:0]    btn_n;
  logic          song_done;
  logic [5:0]    keys_live, keys_playback;
  logic          song_enable, song_select, overrun;
  logic [2:0]    mode;
  logic [AW-1:0] rec_length;

  musicbox_mode_controller_if #(.ADDR_W(AW)) mem_if ();

  musicbox_mode_controller #(
    .DEBOUNCE_CYCLES(DEB), .SAMPLE_DIV(DIV), .MAX_REC_SAMPLES(MAXS), .ADDR_W(AW)
  ) dut (
    .max10Board_50MhzClock              (clk),
    .reset_n                            (rst_n),
    .max10Board_GPIO_Input_MusicKeys    (keys_n),
    .max10Board_GPIO_Input_PlaySong0    (btn_n[0]),
    .max10Board_GPIO_Input_PlaySong1    (btn_n[1]),
    .max10Board_GPIO_Input_MakeRecording(btn_n[2]),
    .max10Board_GPIO_Input_PlayRecording(btn_n[3]),
    .song_done                          (song_done),
    .mem_if                             (mem_if),
    .keys_live                          (keys_live),
    .keys_playback                      (keys_playback),
    .song_enable                        (song_enable),
    .song_select                        (song_select),
    .mode                               (mode),
    .rec_length                         (rec_length),
    .overrun                            (overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: acks ack_delay cycles after mem_req and logs every completed transfer.
  int          ack_delay = 2;
  int          req_age   = 0;
  logic [15:0] sdram_mem [64];
  logic [5:0]  addr6;
  logic [40:0] obs_q[$];
  logic [40:0] exp_q[$];

  initial begin
    for (int i = 0; i < 64; i++) sdram_mem[i] = '0;
    mem_if.mem_ack      = 1'b0;
    mem_if.mem_readData = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        mem_if.mem_ack = 1'b0;
        req_age        = 0;
      end else if (mem_if.mem_ack) begin
        mem_if.mem_ack = 1'b0;
      end else if (mem_if.mem_req) begin
        req_age++;
        if (req_age >= ack_delay) begin
          addr6 = mem_if.mem_address[5:0];
          if (mem_if.mem_write) sdram_mem[addr6] = mem_if.mem_writeData;
          mem_if.mem_readData = sdram_mem[addr6] | (16'($urandom) & 16'hFFC0);
          mem_if.mem_ack      = 1'b1;
          req_age             = 0;
          obs_q.push_back({mem_if.mem_write, mem_if.mem_address, mem_if.mem_writeData});
        end
      end else begin
        req_age = 0;
      end
    end
  end

  // driver tasks
  task automatic tick_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    btn_n = btn_n & ~mask;
    tick_wait(hold);
    btn_n = btn_n | mask;
  endtask

  task automatic set_keys(input logic [5:0] k);
    keys_n = ~k;
    tick_wait(DEB + 4);
  endtask

  task automatic wait_mode(input string tag, input logic [2:0] exp, input int budget);
    int n = 0;
    while (mode !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(mode), 32'(exp));
  endtask

  // scoreboard: a recording of n samples is n writes to 0..n-1 carrying the held keys
  task automatic check_writes(input string tag, input logic [5:0] k, input int n, input bit chk_count);
    logic [40:0] got, exp;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, AW'(i), {10'b0, k}});
    if (chk_count) check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(n));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front();
      exp = exp_q.pop_front();
      check_eq({tag, "_addr"}, 32'(got[39:16]), 32'(exp[39:16]));
      check_eq({tag, "_wdata"}, {15'b0, got[40], got[15:0]}, {15'b0, exp[40], exp[15:0]});
    end
  endtask

  // replay of n samples is n reads of 0..n-1; keys_playback shows the stored keys then clears
  task automatic run_playback(input string tag, input logic [5:0] k, input int n);
    logic [40:0] got;
    int w = 0;
    obs_q.delete();
    press(B_PR, 8);
    while (obs_q.size() == 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_first_ack"}, 32'(obs_q.size() >= 1), 32'd1);
    @(negedge clk);
    if (n > 1) check_eq({tag, "_keys_pb"}, 32'(keys_playback), 32'(k));
    wait_mode({tag, "_end"}, 3'd0, 200);
    tick_wait(DEB + 4);
    check_eq({tag, "_rd_count"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && obs_q.size() > 0; i++) begin
      got = obs_q.pop_front();
      check_eq({tag, "_rd_addr"}, {7'b0, got[40], got[39:16]}, {8'b0, AW'(i)});
    end
    check_eq({tag, "_keys_pb_idle"}, 32'(keys_playback), 32'd0);
  endtask

  logic [5:0] k;
  int         n_rec, stop_mode, w;

  initial begin
    rst_n     = 1'b0;
    keys_n    = '1;
    btn_n     = '1;
    song_done = 1'b0;
    tick_wait(3);
    check_eq("rst_mode", 32'(mode), 32'd0);
    check_eq("rst_req", 32'(mem_if.mem_req), 32'd0);
    check_eq("rst_outs", {7'b0, song_enable, song_select, overrun, keys_live, keys_playback, 10'b0},
             32'd0);
    check_eq("rst_rec_length", 32'(rec_length), 32'd0);
    rst_n = 1'b1;
    tick_wait(2);

    // glitch rejection, SONG0, song_done
    btn_n[0] = 1'b0;
    tick_wait(3);
    btn_n[0] = 1'b1;
    tick_wait(12);
    check_eq("glitch_mode", 32'(mode), 32'd0);
    press(B_PS0, 10);
    check_eq("song0_mode", 32'(mode), 32'd1);
    check_eq("song0_en_sel", {30'b0, song_enable, song_select}, 32'b10);
    tick_wait(DEB + 4);
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    wait_mode("song_done_mode", 3'd0, 2);
    check_eq("song_done_en", 32'(song_enable), 32'd0);

    // fixed recording with auto-stop, then replay
    set_keys(6'b000101);
    check_eq("keys_live", 32'(keys_live), 32'h05);
    obs_q.delete();
    press(B_MK, 8);
    check_eq("rec_mode", 32'(mode), 32'd3);
    wait_mode("rec_autostop", 3'd0, 120);
    tick_wait(2);
    check_writes("rec0", 6'b000101, MAXS, 1'b1);
    check_eq("rec0_length", 32'(rec_length), 32'(MAXS));
    check_eq("rec0_overrun", 32'(overrun), 32'd0);
    run_playback("pb0", 6'b000101, MAXS);

    // PlayRecording outranks PlaySong1 when a recording exists
    press(B_PR | B_PS1, 8);
    check_eq("both_pr_mode", 32'(mode), 32'd4);
    wait_mode("both_pr_end", 3'd0, 120);
    tick_wait(DEB + 4);

    // randomized recordings, either auto-stopped or stopped by a press, each replayed
    for (int it = 0; it < 4; it++) begin
      k         = 6'($urandom_range(1, 63));
      ack_delay = $urandom_range(1, 4);
      stop_mode = $urandom_range(0, 1);
      set_keys(k);
      check_eq("rnd_keys_live", 32'(keys_live), 32'(k));
      obs_q.delete();
      press(B_MK, 8);
      check_eq("rnd_rec_mode", 32'(mode), 32'd3);
      if (stop_mode != 0) begin
        tick_wait(DEB + 4 + $urandom_range(0, 10));
        press(B_MK, 8);
        wait_mode("rnd_stop", 3'd0, 40);
        tick_wait(DEB + 4);
        n_rec = obs_q.size();
        check_eq("rnd_stop_len_range", 32'(n_rec >= 1 && n_rec < MAXS), 32'd1);
      end else begin
        wait_mode("rnd_autostop", 3'd0, 120);
        tick_wait(2);
        n_rec = MAXS;
      end
      check_writes("rnd_rec", k, n_rec, stop_mode == 0);
      check_eq("rnd_rec_length", 32'(rec_length), 32'(n_rec));
      check_eq("rnd_overrun", 32'(overrun), 32'd0);
      if (n_rec > 0) run_playback("rnd_pb", k, n_rec);
    end

    // slow memory: overrun, then stop mid-request through DRAIN
    ack_delay = 12;
    k = 6'($urandom_range(1, 63));
    set_keys(k);
    obs_q.delete();
    press(B_MK, 8);
    w = 0;
    while (obs_q.size() < 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("ovr_two_writes", 32'(obs_q.size()), 32'd2);
    w = 0;
    while (!mem_if.mem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("ovr_third_req", 32'(mem_if.mem_req), 32'd1);
    btn_n = btn_n & ~B_MK;
    wait_mode("ovr_drain", 3'd5, 12);
    wait_mode("ovr_drain_done", 3'd0, 20);
    btn_n = btn_n | B_MK;
    tick_wait(DEB + 4);
    check_eq("ovr_overrun", 32'(overrun), 32'd1);
    check_writes("ovr_rec", k, 3, 1'b1);
    check_eq("ovr_rec_length", 32'(rec_length), 32'd3);

    // asynchronous reset in the middle of a replay read
    ack_delay = 2;
    press(B_PR, 8);
    w = 0;
    while (!mem_if.mem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("arst_req_before", 32'(mem_if.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", 32'(mem_if.mem_req), 32'd0);
    check_eq("arst_mode", 32'(mode), 32'd0);
    check_eq("arst_rec_length", 32'(rec_length), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_wait(2);

    // with no recording PlayRecording is refused and PlaySong1 wins; MakeRecording leaves SONG1
    press(B_PR | B_PS1, 8);
    check_eq("both_s1_mode", 32'(mode), 32'd2);
    check_eq("both_s1_en_sel", {30'b0, song_enable, song_select}, 32'b11);
    tick_wait(DEB + 4);
    press(B_MK, 8);
    check_eq("song1_exit_mode", 32'(mode), 32'd0);
    check_eq("song1_exit_en", 32'(song_enable), 32'd0);
    tick_wait(DEB + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/musicbox_mode_controller.md
# musicbox_mode_controller

Mode controller for the MusicBox top level. Conditions the raw active-low GPIO user inputs (six music keys, Play Song 0/1, Make Recording, Play Recording) and runs the box's operating mode. It arbitrates between song playback, recording and recording playback. While recording or replaying, it schedules sample-rate key-state transfers to and from SDRAM through a single req/ack port in front of the SDRAM interface.

## Interface
- DEBOUNCE_CYCLES, 500000, cycles an input must be stable before its debounced value changes (10 ms at 50 MHz)
- SAMPLE_DIV, 6250, clock cycles per sample tick (8 kHz)
- MAX_REC_SAMPLES, 240000, recording capacity in samples (30 s)
- ADDR_W, 24, SDRAM word address width

- max10Board_50MhzClock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- max10Board_GPIO_Input_MusicKeys  in  6  raw keys, active low
- max10Board_GPIO_Input_PlaySong0 / PlaySong1 / MakeRecording / PlayRecording  in  1 each  raw buttons, active low
- song_done  in  1  one-cycle pulse from the song sequencer at end of song
- mem_ack  in  1  one-cycle acknowledge of the current request
- mem_readData  in  16  read data, valid with mem_ack
- mem_req  out  1  transfer request, held until mem_ack
- mem_write  out  1  1 = write, 0 = read; stable while mem_req
- mem_address  out  ADDR_W  word address; stable while mem_req
- mem_writeData  out  16  {10'b0, sampled keys}
- keys_live  out  6  debounced keys, active high
- keys_playback  out  6  replayed key state
- song_enable  out  1  song sequencer run
- song_select  out  1  0 = song 0, 1 = song 1
- mode  out  3  IDLE=0, SONG0=1, SONG1=2, RECORD=3, PLAYBACK=4, DRAIN=5
- rec_length  out  ADDR_W  samples held in the stored recording
- overrun  out  1  sticky: a sample tick was dropped during RECORD or PLAYBACK

## Operation
- Input conditioning, all 10 inputs: 2-flop synchronizer, then an independent debounce counter, then inversion to active high. A button press event is a one-cycle pulse on the debounced 0→1 edge.
- Sample tick: one-cycle pulse every SAMPLE_DIV cycles. The counter is free-running from reset.
- IDLE:
  - Press events have fixed priority: MakeRecording > PlayRecording > PlaySong0 > PlaySong1. Only the highest-priority press in a cycle is acted on.
  - MakeRecording → RECORD. Clears rec_ptr, rec_length and overrun.
  - PlayRecording → PLAYBACK. Clears play_ptr. Ignored (stay IDLE) if rec_length == 0.
  - PlaySong0/1 → SONG0/SONG1.
- SONG0/SONG1:
  - song_enable = 1; song_select = 0 or 1 respectively.
  - song_done or any button press event → IDLE.
- RECORD:
  - Each tick with no request outstanding issues a write: address rec_ptr, data {10'b0, keys_live} captured at the tick.
  - On mem_ack, rec_ptr increments and rec_length = rec_ptr + 1.
  - A tick while mem_req is high is dropped and sets overrun.
  - Any button press event, or an ack that makes rec_ptr == MAX_REC_SAMPLES, ends recording: → DRAIN if a request is still outstanding, else → IDLE.
- PLAYBACK:
  - Each tick with no request outstanding issues a read at play_ptr.
  - On mem_ack, keys_playback = mem_readData[5:0] and play_ptr increments.
  - The ack that makes play_ptr == rec_length → IDLE.
  - A button press event → DRAIN if a request is outstanding, else → IDLE.
  - Overrun rule is the same as RECORD.
- DRAIN: issues no new request; the outstanding request completes normally (including the rec_length update). On mem_ack → IDLE.
- On entry to IDLE: keys_playback = 0, song_enable = 0. rec_length is retained until the next MakeRecording.
- mem_ack received while mem_req is low is ignored.

## Timing
- Reset values: all outputs 0. mode = IDLE, rec_length = 0, overrun = 0. Pointers, debounce and tick counters are 0. Debounced inputs reset to released.
- Press latency: 2 synchronizer cycles + DEBOUNCE_CYCLES stable cycles, then the press pulse. mode changes the following cycle.
- mem_req rises the cycle after the tick and falls the cycle after mem_ack. Earliest next request is at the next tick. Address, write and data are registered together with mem_req.
- Asserting reset_n low mid-transfer drops mem_req immediately. The recording is discarded (rec_length = 0).

## Test plan
Use DEBOUNCE_CYCLES=4, SAMPLE_DIV=8, MAX_REC_SAMPLES=5, and an SDRAM model that acks 2 cycles after req.

1. 3-cycle glitch on PlaySong0 → no mode change. Hold low for 10 cycles → mode=1, song_enable=1, song_select=0. Pulse song_done → mode=0.
2. MakeRecording with keys = 6'b000101 → 5 writes to addresses 0..4 with data 16'h0005. Recording auto-stops: mode=0, rec_length=5, overrun=0.
3. PlayRecording after scenario 2 → 5 reads at addresses 0..4; keys_playback=6'b000101 after the first ack. Returns to IDLE; keys_playback=0.
4. PlayRecording and PlaySong1 pressed on the same cycle → mode=4 (PLAYBACK). With rec_length=0, same stimulus → mode=2 (SONG1).
5. Model ack delayed to 12 cycles during RECORD → overrun=1, one tick dropped per slow request. Press MakeRecording mid-request → mode=5 until ack, then mode=0, and rec_length counts that acked write.
6. reset_n low during PLAYBACK with mem_req=1 → mem_req=0, mode=0 and rec_length=0 asynchronously.
